// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM encoding, latency and
// divide-by-zero quotient.
package div_pkg;

  localparam int unsigned DIV_LAT = 34;
  localparam logic [31:0] DZ_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/div_iter_unit_adder.sv
// 32-bit adder with carry in/out, shared with the EX-stage ALU datapath.
module div_iter_unit_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {32'd0, ci};

endmodule

// File: rtl/div_iter_unit.sv
// Restoring radix-2 divider for div.w/mod.w/div.wu/mod.wu: one quotient bit
// per cycle, trial subtraction on the shared adder, sign fix-up at the end.
module div_iter_unit #(
  parameter int unsigned       WIDTH   = 32,
  parameter logic [WIDTH-1:0]  DZ_QUOT = div_pkg::DZ_QUOT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  import div_pkg::*;

  div_state_e       state, state_nx;
  logic [WIDTH-1:0] dvd, dvs, quot, rem;
  logic [4:0]       count;
  logic             q_neg, r_neg;
  logic [WIDTH:0]   rs;
  logic [WIDTH-1:0] diff;
  logic             co, ge, accept, dz;

  assign accept = (state == S_IDLE) && start && !cancel;
  assign dz     = (divisor == '0);

  // rem stays below the divisor, so 32 bits suffice; rs carries the 33rd bit.
  assign rs = {rem, dvd[WIDTH-1]};
  assign ge = rs[WIDTH] | co;

  div_iter_unit_adder u_add (
    .a  (rs[WIDTH-1:0]),
    .b  (~dvs),
    .ci (1'b1),
    .s  (diff),
    .co (co)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = dz ? S_DONE : S_CALC;
      S_CALC: begin
        if (cancel)                              state_nx = S_IDLE;
        else if (count == 5'(DIV_LAT - 3))       state_nx = S_SIGN;
      end
      S_SIGN: state_nx = cancel ? S_IDLE : S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      dvd       <= '0;
      dvs       <= '0;
      quot      <= '0;
      rem       <= '0;
      count     <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (accept) begin
          div_zero <= dz;
          q_neg    <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_neg    <= is_signed & dividend[WIDTH-1];
          dvd      <= (is_signed && dividend[WIDTH-1]) ? neg32(dividend) : dividend;
          dvs      <= (is_signed && divisor[WIDTH-1])  ? neg32(divisor)  : divisor;
          rem      <= '0;
          quot     <= '0;
          count    <= '0;
          if (dz) begin
            quotient  <= DZ_QUOT;
            remainder <= dividend;
          end
        end
        S_CALC: begin
          rem   <= ge ? diff : rs[WIDTH-1:0];
          quot  <= {quot[WIDTH-2:0], ge};
          dvd   <= {dvd[WIDTH-2:0], 1'b0};
          count <= count + 5'd1;
        end
        S_SIGN: if (!cancel) begin
          quotient  <= q_neg ? neg32(quot) : quot;
          remainder <= r_neg ? neg32(rem)  : rem;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == S_CALC) || (state == S_SIGN);
  assign done = (state == S_DONE);

endmodule
